ym_bus_sequencer: RTL and testbench

YM_BUS_SEQUENCER -- requirements
Module: ym_bus_sequencer

---
 rtl/turbofm_pkg.sv | 30 +++
 rtl/ym_bus_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ym_bus_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/turbofm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : turbofm_pkg
// Purpose  : Shared types and constants for the YM chip bus sequencer:
//            FSM state encoding, default bus timing, chip index values.
// Revision : 1.0 - initial release
// ============================================================================
package turbofm_pkg;

    // Bus cycle phases, in the order a cycle walks through them
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RECOV  = 3'd4
    } seq_state_t;

    // Default bus timing in fclk cycles
    localparam int T_SETUP_DEF  = 2;
    localparam int T_STROBE_DEF = 6;
    localparam int T_HOLD_DEF   = 2;
    localparam int T_RECOV_DEF  = 4;

    // Chip index values carried in req_chip
    localparam logic YM1 = 1'b0;
    localparam logic YM2 = 1'b1;

endpackage : turbofm_pkg
`default_nettype wire

// File: rtl/ym_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ym_bus_sequencer
// Purpose  : Turns one-cycle AY-bus requests into timed read/write cycles on
//            the YM chip bus (setup / strobe / hold / recovery), with a
//            one-entry request buffer and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module ym_bus_sequencer
    import turbofm_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int T_RECOV  = T_RECOV_DEF
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_wr,
    input  logic       req_chip,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       ready,
    output logic       overflow,
    output logic       ymcs1_n,
    output logic       ymcs2_n,
    output logic       ymwr_n,
    output logic       ymrd_n,
    output logic       yma0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    // Counter only ever holds T_x - 1, so clog2 of the largest T_x is enough
    localparam int MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int MAX_B = (T_HOLD  > T_RECOV)  ? T_HOLD  : T_RECOV;
    localparam int MAX_T = (MAX_A   > MAX_B)    ? MAX_A   : MAX_B;
    localparam int CW    = (MAX_T <= 1) ? 1 : $clog2(MAX_T);

    seq_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          launch;
    logic          launch_idle;
    logic          accept;
    logic          full, full_n;

    // One-entry request buffer
    logic          buf_wr, buf_chip, buf_a0;
    logic [7:0]    buf_data;

    // Attributes of the cycle currently on the bus
    logic          cyc_wr, cyc_chip;

    // Attributes of the cycle that will be on the bus after this edge
    logic          sel_wr, sel_chip, active_n;

    // A launch from IDLE frees the buffer in the same edge, so a req arriving
    // alongside it can take the slot instead of being dropped.
    assign launch_idle = (state == ST_IDLE) && full;
    assign ready       = !full || launch_idle;
    assign accept      = req && ready;

    assign sel_wr   = launch ? buf_wr   : cyc_wr;
    assign sel_chip = launch ? buf_chip : cyc_chip;
    assign active_n = (state_n == ST_SETUP) || (state_n == ST_STROBE) ||
                      (state_n == ST_HOLD);

    // Next-state and counter logic; every timed state ends when cnt reaches 0
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        launch  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (full) begin
                    launch  = 1'b1;
                    state_n = ST_SETUP;
                    cnt_n   = CW'(T_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_n = ST_STROBE;
                    cnt_n   = CW'(T_STROBE - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_n = ST_HOLD;
                    cnt_n   = CW'(T_HOLD - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_n = ST_RECOV;
                    cnt_n   = CW'(T_RECOV - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_RECOV: begin
                if (cnt == '0) begin
                    if (full) begin
                        launch  = 1'b1;
                        state_n = ST_SETUP;
                        cnt_n   = CW'(T_SETUP - 1);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Buffer fill/drain: a launch empties it, an accepted req refills it
    always_comb begin
        full_n = full;
        if (launch) full_n = 1'b0;
        if (accept) full_n = 1'b1;
    end

    // State register, phase counter and active-cycle attributes
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cyc_wr   <= 1'b0;
            cyc_chip <= YM1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (launch) begin
                cyc_wr   <= buf_wr;
                cyc_chip <= buf_chip;
            end
        end
    end

    // Request buffer and sticky overflow
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            overflow <= 1'b0;
            buf_wr   <= 1'b0;
            buf_chip <= YM1;
            buf_a0   <= 1'b0;
            buf_data <= 8'h00;
        end else begin
            full <= full_n;
            if (accept) begin
                buf_wr   <= req_wr;
                buf_chip <= req_chip;
                buf_a0   <= req_a0;
                buf_data <= req_data;
            end
            if (req && !accept) overflow <= 1'b1;
        end
    end

    // Bus outputs registered from the next state so they never glitch
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            ymcs1_n <= 1'b1;
            ymcs2_n <= 1'b1;
            ymwr_n  <= 1'b1;
            ymrd_n  <= 1'b1;
            yma0    <= 1'b0;
            d_out   <= 8'h00;
            d_oe    <= 1'b0;
        end else begin
            ymcs1_n <= !(active_n && (sel_chip == YM1));
            ymcs2_n <= !(active_n && (sel_chip == YM2));
            ymwr_n  <= !((state_n == ST_STROBE) &&  sel_wr);
            ymrd_n  <= !((state_n == ST_STROBE) && !sel_wr);
            d_oe    <= active_n && sel_wr;
            if (launch) begin
                yma0 <= buf_a0;
                if (buf_wr) d_out <= buf_data;
            end
        end
    end

    // Read data is sampled on the last strobe cycle, flagged one cycle later
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if ((state == ST_STROBE) && (cnt == '0) && !cyc_wr) begin
                rd_data  <= d_in;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule : ym_bus_sequencer
`default_nettype wire

// File: tb/tb_ym_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ym_bus_sequencer
// Purpose  : Directed self-checking bench for ym_bus_sequencer at default
//            timing: write, read, back-to-back, overflow, mid-strobe reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ym_bus_sequencer;

    logic       fclk = 1'b0;
    logic       rst  = 1'b1;
    logic       req  = 1'b0;
    logic       req_wr = 1'b0;
    logic       req_chip = 1'b0;
    logic       req_a0 = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       ready, overflow, ymcs1_n, ymcs2_n, ymwr_n, ymrd_n, yma0;
    logic [7:0] d_out, d_in, rd_data;
    logic       d_oe, rd_valid;

    int checks   = 0;
    int failures = 0;

    // Per-test activity counters, updated only by the stimulus process
    int cyc, n_cs1, n_cs2, n_wr, n_rd, n_oe, n_dok, n_a0, n_rv, n_fall, n_rise;
    int t_rise1, t_fall2;
    logic [7:0] exp_d;
    logic prev_cs1;

    // Protocol violation counters, updated only by the monitor process
    int v_cs = 0, v_strb = 0, v_oe = 0;

    ym_bus_sequencer dut (
        .fclk     (fclk),
        .rst      (rst),
        .req      (req),
        .req_wr   (req_wr),
        .req_chip (req_chip),
        .req_a0   (req_a0),
        .req_data (req_data),
        .ready    (ready),
        .overflow (overflow),
        .ymcs1_n  (ymcs1_n),
        .ymcs2_n  (ymcs2_n),
        .ymwr_n   (ymwr_n),
        .ymrd_n   (ymrd_n),
        .yma0     (yma0),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .d_in     (d_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 fclk = ~fclk;

    // The addressed chip only drives the bus while its read strobe is low
    assign d_in = ymrd_n ? 8'h00 : 8'hC3;

    // Bus-wide exclusion rules, checked every cycle of every test
    always @(negedge fclk) begin
        if (!ymcs1_n && !ymcs2_n) v_cs++;
        if (!ymwr_n && !ymrd_n)   v_strb++;
        if (d_oe && !ymrd_n)      v_oe++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_counts();
        cyc = 0; n_cs1 = 0; n_cs2 = 0; n_wr = 0; n_rd = 0; n_oe = 0;
        n_dok = 0; n_a0 = 0; n_rv = 0; n_fall = 0; n_rise = 0;
        t_rise1 = -1; t_fall2 = -1; prev_cs1 = ymcs1_n;
    endtask

    task automatic sample();
        cyc++;
        if (!ymcs1_n) n_cs1++;
        if (!ymcs2_n) n_cs2++;
        if (!ymwr_n)  n_wr++;
        if (!ymrd_n)  n_rd++;
        if (d_oe)     n_oe++;
        if (!ymcs1_n && d_oe && d_out == exp_d) n_dok++;
        if (!ymcs2_n && yma0) n_a0++;
        if (rd_valid) n_rv++;
        if (prev_cs1 && !ymcs1_n) begin
            n_fall++;
            if (n_fall == 2) t_fall2 = cyc;
        end
        if (!prev_cs1 && ymcs1_n) begin
            n_rise++;
            if (n_rise == 1) t_rise1 = cyc;
        end
        prev_cs1 = ymcs1_n;
    endtask

    // One fclk cycle: sample outputs at the falling edge, then drive inputs
    task automatic step(input logic r, input logic wr, input logic chip,
                        input logic a0, input logic [7:0] data);
        @(negedge fclk);
        sample();
        req = r; req_wr = wr; req_chip = chip; req_a0 = a0; req_data = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        exp_d = 8'h00;
        clear_counts();

        // Reset state
        repeat (3) @(negedge fclk);
        check("rst_cs1", ymcs1_n, 1);
        check("rst_cs2", ymcs2_n, 1);
        check("rst_wr",  ymwr_n, 1);
        check("rst_rd",  ymrd_n, 1);
        check("rst_a0",  yma0, 0);
        check("rst_dout", d_out, 0);
        check("rst_doe", d_oe, 0);
        check("rst_rdd", rd_data, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdy", ready, 1);
        rst = 1'b0;
        idle(2);

        // Write, chip 1, a0=0, data 0x5A
        clear_counts();
        exp_d = 8'h5A;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        idle(25);
        check("wr_cs1_len", n_cs1, 10);
        check("wr_wr_len",  n_wr, 6);
        check("wr_cs2",     n_cs2, 0);
        check("wr_rd",      n_rd, 0);
        check("wr_data_ok", n_dok, 10);
        check("wr_oe_len",  n_oe, 10);

        // Read, chip 2, a0=1
        clear_counts();
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        idle(25);
        check("rd_cs2_len", n_cs2, 10);
        check("rd_rd_len",  n_rd, 6);
        check("rd_cs1",     n_cs1, 0);
        check("rd_oe",      n_oe, 0);
        check("rd_a0",      n_a0, 10);
        check("rd_valid_n", n_rv, 1);
        check("rd_data",    rd_data, 8'hC3);

        // Back-to-back writes in consecutive cycles
        clear_counts();
        exp_d = 8'h22;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
        idle(40);
        check("b2b_ovf",   overflow, 0);
        check("b2b_falls", n_fall, 2);
        check("b2b_gap",   t_fall2 - t_rise1, 4);
        check("b2b_cs1",   n_cs1, 20);
        check("b2b_data2", n_dok, 10);

        // Three requests in consecutive cycles: third is dropped
        clear_counts();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
        @(negedge fclk);
        sample();
        check("ovf_ready", ready, 0);
        req = 1'b1; req_wr = 1'b1; req_chip = 1'b0; req_data = 8'h03;
        idle(45);
        check("ovf_flag",  overflow, 1);
        check("ovf_falls", n_fall, 2);
        idle(10);
        check("ovf_sticky", overflow, 1);

        // Reset during the third strobe cycle of a write
        clear_counts();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        begin : wait_strobe
            int budget;
            budget = 0;
            while (ymwr_n && budget < 20) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                budget++;
            end
            check("mid_strobe_seen", ymwr_n, 0);
        end
        repeat (2) @(posedge fclk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr",  ymwr_n, 1);
        check("mid_rst_cs1", ymcs1_n, 1);
        check("mid_rst_ovf", overflow, 0);
        @(negedge fclk);
        rst = 1'b0;
        clear_counts();
        idle(30);
        check("post_rst_falls", n_fall, 0);
        check("post_rst_cs1",   n_cs1, 0);

        // First request after reset runs a complete cycle
        clear_counts();
        exp_d = 8'h3C;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(25);
        check("post_rst_len", n_cs1, 10);
        check("post_rst_wr",  n_wr, 6);
        check("post_rst_dat", n_dok, 10);

        // Exclusion rules over the whole run
        check("mon_cs_excl",   v_cs, 0);
        check("mon_strb_excl", v_strb, 0);
        check("mon_oe_rd",     v_oe, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ym_bus_sequencer
`default_nettype wire
